// File: rtl/nonce_dispatch_multi_pkg.sv
// rtl/nonce_dispatch_multi_pkg.sv - state encoding and pipeline offset helper shared by the nonce dispatcher
package nonce_dispatch_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } dispatch_state_t;

  // Steps between a nonce entering the hasher pair and its second-stage hash top being visible.
  function automatic logic [7:0] pipe_offset(input int loop_log2);
    return 8'((1 << (7 - loop_log2)) + 1);
  endfunction

endpackage

// File: rtl/golden_nonce_fifo.sv
// rtl/golden_nonce_fifo.sv - 2^DEPTH_LOG2 x 32 synchronous FIFO holding golden nonces
module golden_nonce_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/nonce_dispatch_multi.sv
// rtl/nonce_dispatch_multi.sv - N-lane miner control: round counter, lane nonces, golden ticket capture and hand-off
// Optional SHARE_TARGET_EN adds share_target and hits on top <= share_target instead of top == 0.
module nonce_dispatch_multi
  import nonce_dispatch_multi_pkg::*;
#(
  parameter int LOOP_LOG2 = 2,
  parameter int LANE_LOG2 = 1,
  parameter int FIFO_LOG2 = 3
) (
  input  logic                         hash_clk,
  input  logic                         reset_n,
  input  logic                         work_valid,
  output logic [5:0]                   cnt,
  output logic                         feedback,
  output logic [(1<<LANE_LOG2)*32-1:0] lane_nonce,
  input  logic [(1<<LANE_LOG2)*32-1:0] lane_hash_top,
`ifdef SHARE_TARGET_EN
  input  logic [31:0]                  share_target,
`endif
  output logic                         nonce_valid,
  input  logic                         nonce_ready,
  output logic [31:0]                  nonce_data,
  output logic                         hashing,
  output logic                         exhausted,
  output logic [7:0]                   drop_count
);

  localparam int                NUM_LANES = 1 << LANE_LOG2;
  localparam int                LOOP      = 1 << LOOP_LOG2;
  localparam int                BASE_W    = 32 - LANE_LOG2;
  localparam logic [7:0]        OFFSET    = pipe_offset(LOOP_LOG2);
  localparam logic [5:0]        CNT_MASK  = 6'(LOOP - 1);
  localparam logic [BASE_W-1:0] BASE_MAX  = '1;

  dispatch_state_t      state;
  dispatch_state_t      state_next;
  logic [5:0]           cnt_next;
  logic                 step;
  logic                 feedback_d1;
  logic                 hit_en;
  logic [BASE_W-1:0]    base;
  logic [BASE_W-1:0]    base_next;
  logic [7:0]           blank_cnt;
  logic [7:0]           drain_cnt;
  logic [NUM_LANES-1:0] hit_raw;
  logic [NUM_LANES-1:0] hit_q;
  logic [NUM_LANES-1:0] hold_full;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] push_grant;
  logic [NUM_LANES-1:0] load_vec;
  logic [NUM_LANES-1:0] drop_vec;
  logic [31:0]          hold_val [NUM_LANES];
  logic [31:0]          push_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 can_push;
  logic [5:0]           drop_inc;
  logic [8:0]           drop_sum;

  assign cnt_next = (cnt + 6'd1) & CNT_MASK;
  assign step     = (cnt_next == 6'd0);
  assign hit_en   = hashing && (blank_cnt == 8'd0);

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    base_next  = base;
    hashing    = 1'b0;
    exhausted  = 1'b0;
    case (state)
      ST_IDLE: base_next = '0;
      ST_RUN: begin
        hashing = 1'b1;
        if (step) begin
          base_next = base + BASE_W'(1);
          if (base == BASE_MAX) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        hashing = 1'b1;
        if (step) begin
          base_next = base + BASE_W'(1);
          if (drain_cnt == 8'd1) state_next = ST_EXHAUSTED;
        end
      end
      ST_EXHAUSTED: exhausted = 1'b1;
      default: state_next = ST_IDLE;
    endcase
    if (work_valid) begin
      state_next = ST_RUN;
      base_next  = '0;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      feedback    <= 1'b0;
      feedback_d1 <= 1'b0;
      base        <= '0;
      blank_cnt   <= '0;
      drain_cnt   <= '0;
      hit_q       <= '0;
    end else begin
      cnt         <= work_valid ? 6'd0 : cnt_next;
      feedback    <= !work_valid && (cnt_next != 6'd0);
      feedback_d1 <= feedback;
      base        <= base_next;
      hit_q       <= work_valid ? '0 : (hit_raw & {NUM_LANES{hit_en && !feedback_d1}});
      // Hashes seen during the first OFFSET steps still belong to the previous work.
      if (work_valid)                     blank_cnt <= OFFSET;
      else if (step && blank_cnt != 8'd0) blank_cnt <= blank_cnt - 8'd1;
      if (state == ST_RUN && state_next == ST_DRAIN) drain_cnt <= OFFSET;
      else if (state == ST_DRAIN && step)            drain_cnt <= drain_cnt - 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_nonce[32*i +: 32] = (32'(i) << BASE_W) | 32'(base);
`ifdef SHARE_TARGET_EN
    assign hit_raw[i] = (lane_hash_top[32*i +: 32] <= share_target);
`else
    assign hit_raw[i] = (lane_hash_top[32*i +: 32] == 32'd0);
`endif
  end

  // Lowest-index full hold owns the FIFO write port this cycle.
  always_comb begin
    grant     = '0;
    push_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hold_full[i] && grant == '0) begin
        grant[i]  = 1'b1;
        push_data = hold_val[i];
      end
    end
  end

  assign fifo_pop   = nonce_valid && nonce_ready;
  assign can_push   = !fifo_full || fifo_pop;
  assign push_grant = can_push ? grant : '0;
  assign fifo_push  = |push_grant;
  assign load_vec   = work_valid ? '0 : (hit_q & (~hold_full | push_grant));
  assign drop_vec   = work_valid ? '0 : (hit_q & hold_full & ~push_grant);

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_LANES; i++) drop_inc = drop_inc + 6'(drop_vec[i]);
  end

  assign drop_sum = {1'b0, drop_count} + {3'b000, drop_inc};

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full  <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (load_vec[i])        hold_full[i] <= 1'b1;
        else if (push_grant[i]) hold_full[i] <= 1'b0;
      end
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (load_vec[i]) hold_val[i] <= lane_nonce[32*i +: 32] - 32'(OFFSET);
    end
  end

  golden_nonce_fifo #(
    .DEPTH_LOG2(FIFO_LOG2)
  ) u_fifo (
    .clk       (hash_clk),
    .rst_n     (reset_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (nonce_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign nonce_valid = !fifo_empty;

endmodule
